rle_encoder_param: RTL
======================

# rle_encoder_param

Parametrised run-length encoder with valid/ready handshakes on both sides, sitting between the byte source and the output packer in the compression datapath. Runs of at least MIN_RUN identical symbols, and any run of the escape symbol, are emitted as the triple {ESC, count, symbol}. Shorter runs pass through as literals. Runs saturate at the maximum count, and an explicit end-of-stream input flushes pending data.

## Interface
- DATA_W, 8: symbol and output word width.
- CNT_W, 8: run counter width; must be ≤ DATA_W. MAX_RUN = 2^CNT_W − 1.
- ESC, 8'h1B: escape symbol, DATA_W bits.
- MIN_RUN, 3: shortest run that is encoded; legal range 2..MAX_RUN.
- data_clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- Data_In  in  DATA_W  input symbol.
- in_valid  in  1  Data_In is valid.
- in_last  in  1  qualifies the accepted symbol as the final symbol of the stream.
- in_ready  out  1  encoder accepts; a transfer occurs when in_valid && in_ready.
- Data_out  out  DATA_W  encoded word; the count is zero-extended.
- Data_valid  out  1  Data_out is valid.
- out_ready  in  1  downstream accepts; a beat transfers when Data_valid && out_ready.
- stat_in_count, stat_out_count  out  32  present only with RLE_STATS_EN.

## Operation
- State: IDLE (no run held), RUN (run held as cur_sym/cur_cnt), EMIT (emitting a run).
- in_ready = 1 in IDLE and RUN, 0 in EMIT and while reset is high.
- IDLE, accept s: cur_sym=s, cur_cnt=1, go to RUN.
- RUN, accept s == cur_sym, cur_cnt < MAX_RUN: cur_cnt++.
- RUN, accept s != cur_sym, or cur_cnt == MAX_RUN: latch the run for emission; the held run becomes {s, 1}; go to EMIT.
- in_last on an accepted beat: the symbol is first merged as above. The pending run(s) are then emitted, the held run last, and the FSM returns to IDLE with no run held.
- Run form for symbol x, count n:
  - Encoded when n ≥ MIN_RUN or x == ESC: beats ESC, n, x.
  - Literal otherwise: n beats of x.
- EMIT leaves after its final beat transfers:
  - to RUN, or back to EMIT if a last-flush of the held run remains;
  - to IDLE once the flush completes.
- out_ready low: Data_out and Data_valid hold; no beat is dropped or duplicated.
- in_last in IDLE with no symbol is impossible by construction: in_last only qualifies an accepted symbol.

## Timing
- Reset values: Data_out=0, Data_valid=0, in_ready=0 during reset; state=IDLE, cur_cnt=0, stats=0. in_ready=1 on the first cycle after reset falls.
- Data_out and Data_valid are registered.
- Run-break latency: the first beat is valid on the cycle after the accepting edge.
- One beat per cycle while out_ready is high.
- An encoded run costs 3 cycles of in_ready=0; a literal run costs n cycles.
- Saturation: MAX_RUN+1 identical symbols produce {ESC, MAX_RUN, x}, followed later by the held run {x, 1}.
- Reset mid-EMIT: the current beat is abandoned, the held run is discarded, and the FSM returns to IDLE on the next edge.

## Configuration
- RLE_STATS_EN defined:
  - stat_in_count increments on each input transfer; stat_out_count increments on each output transfer.
  - Both are 32-bit, saturate at 2^32−1, and are cleared by reset.
- Undefined: both ports and counters are absent. Encoding behaviour is identical either way.

## Test plan
- Defaults, input 41,41,41,41,42(last), out_ready=1 -> output 1B,04,41,42; Data_valid drops after the last beat; back in IDLE.
- Input 41,41,43(last) -> 41,41,43; no escape triple.
- Single 1B(last) -> 1B,01,1B; 1B,1B,1B,1B(last) -> 1B,04,1B.
- 256 × 55 then 56(last), CNT_W=8 -> 1B,FF,55, then 55, then 56.
- out_ready toggled 1/0 every cycle during 1B,05,41 -> each word held while out_ready=0; exactly 3 transfers in order; in_ready=0 throughout.
- Reset asserted on the 2nd beat of a triple -> Data_valid=0 next edge; a new stream 60(last) -> output 60 only. With RLE_STATS_EN, stats read 0 after reset and 1/1 after the stream.

Source files
------------

// File: rtl/rle_encoder_param.sv
// rtl/rle_encoder_param.sv - parametrised run-length encoder with valid/ready on both sides
// Optional transfer counters stat_in_count/stat_out_count exist only when RLE_STATS_EN is defined.
`timescale 1ns/1ps
module rle_encoder_param #(
    parameter int                DATA_W  = 8,
    parameter int                CNT_W   = 8,
    parameter logic [DATA_W-1:0] ESC     = 8'h1B,
    parameter int                MIN_RUN = 3
) (
    input  logic              data_clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_valid,
    input  logic              out_ready
`ifdef RLE_STATS_EN
    ,
    output logic [31:0]       stat_in_count,
    output logic [31:0]       stat_out_count
`endif
);

    localparam logic [CNT_W-1:0] MAX_RUN   = '1;
    localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EMIT} state_t;

    state_t              r_state, w_state;
    logic [DATA_W-1:0]   r_cur_sym, w_cur_sym;
    logic [CNT_W-1:0]    r_cur_cnt, w_cur_cnt;
    logic [DATA_W-1:0]   r_emit_sym, w_emit_sym;
    logic [CNT_W-1:0]    r_emit_cnt, w_emit_cnt;
    logic [CNT_W-1:0]    r_beat, w_beat;
    logic                r_flush, w_flush;
    logic [DATA_W-1:0]   r_data_out, w_data_out;
    logic                r_data_valid, w_data_valid;
    logic                w_start;
    logic                w_in_fire;
    logic                w_out_fire;

    function automatic logic is_encoded(input logic [DATA_W-1:0] sym, input logic [CNT_W-1:0] cnt);
        return (cnt >= MIN_RUN_C) || (sym == ESC);
    endfunction

    function automatic logic [DATA_W-1:0] beat_word(input logic [DATA_W-1:0] sym,
                                                    input logic [CNT_W-1:0]  cnt,
                                                    input logic [CNT_W-1:0]  idx);
        logic [DATA_W-1:0] w;
        w = sym;
        if (is_encoded(sym, cnt)) begin
            if (idx == CNT_W'(0)) begin
                w = ESC;
            end else if (idx == CNT_W'(1)) begin
                w              = '0;
                w[CNT_W-1:0]   = cnt;
            end
        end
        return w;
    endfunction

    function automatic logic is_last_beat(input logic [DATA_W-1:0] sym,
                                          input logic [CNT_W-1:0]  cnt,
                                          input logic [CNT_W-1:0]  idx);
        if (is_encoded(sym, cnt))
            return idx == CNT_W'(2);
        return idx == (cnt - CNT_W'(1));
    endfunction

    assign in_ready   = !reset && (r_state != S_EMIT);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_data_valid && out_ready;
    assign Data_out   = r_data_out;
    assign Data_valid = r_data_valid;

    always_comb begin
        w_state      = r_state;
        w_cur_sym    = r_cur_sym;
        w_cur_cnt    = r_cur_cnt;
        w_emit_sym   = r_emit_sym;
        w_emit_cnt   = r_emit_cnt;
        w_beat       = r_beat;
        w_flush      = r_flush;
        w_data_out   = r_data_out;
        w_data_valid = r_data_valid;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    if (in_last) begin
                        w_emit_sym = Data_In;
                        w_emit_cnt = CNT_W'(1);
                        w_cur_cnt  = '0;
                        w_flush    = 1'b0;
                        w_start    = 1'b1;
                    end else begin
                        w_cur_sym = Data_In;
                        w_cur_cnt = CNT_W'(1);
                        w_state   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_in_fire) begin
                    if (Data_In == r_cur_sym && r_cur_cnt != MAX_RUN) begin
                        if (in_last) begin
                            w_emit_sym = r_cur_sym;
                            w_emit_cnt = r_cur_cnt + CNT_W'(1);
                            w_cur_cnt  = '0;
                            w_flush    = 1'b0;
                            w_start    = 1'b1;
                        end else begin
                            w_cur_cnt = r_cur_cnt + CNT_W'(1);
                        end
                    end else begin
                        // Run broke or saturated: the new symbol becomes the held run.
                        w_emit_sym = r_cur_sym;
                        w_emit_cnt = r_cur_cnt;
                        w_cur_sym  = Data_In;
                        w_cur_cnt  = CNT_W'(1);
                        w_flush    = in_last;
                        w_start    = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (w_out_fire) begin
                    if (!is_last_beat(r_emit_sym, r_emit_cnt, r_beat)) begin
                        w_beat     = r_beat + CNT_W'(1);
                        w_data_out = beat_word(r_emit_sym, r_emit_cnt, r_beat + CNT_W'(1));
                    end else if (r_flush) begin
                        w_emit_sym = r_cur_sym;
                        w_emit_cnt = r_cur_cnt;
                        w_cur_cnt  = '0;
                        w_flush    = 1'b0;
                        w_start    = 1'b1;
                    end else begin
                        w_data_valid = 1'b0;
                        w_state      = (r_cur_cnt == '0) ? S_IDLE : S_RUN;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
        if (w_start) begin
            w_beat       = '0;
            w_data_out   = beat_word(w_emit_sym, w_emit_cnt, '0);
            w_data_valid = 1'b1;
            w_state      = S_EMIT;
        end
    end

    always_ff @(posedge data_clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cur_sym    <= '0;
            r_cur_cnt    <= '0;
            r_emit_sym   <= '0;
            r_emit_cnt   <= '0;
            r_beat       <= '0;
            r_flush      <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cur_sym    <= w_cur_sym;
            r_cur_cnt    <= w_cur_cnt;
            r_emit_sym   <= w_emit_sym;
            r_emit_cnt   <= w_emit_cnt;
            r_beat       <= w_beat;
            r_flush      <= w_flush;
            r_data_out   <= w_data_out;
            r_data_valid <= w_data_valid;
        end
    end

`ifdef RLE_STATS_EN
    logic [31:0] r_stat_in;
    logic [31:0] r_stat_out;

    always_ff @(posedge data_clock) begin
        if (reset) begin
            r_stat_in  <= '0;
            r_stat_out <= '0;
        end else begin
            if (w_in_fire && r_stat_in != '1)
                r_stat_in <= r_stat_in + 32'd1;
            if (w_out_fire && r_stat_out != '1)
                r_stat_out <= r_stat_out + 32'd1;
        end
    end

    assign stat_in_count  = r_stat_in;
    assign stat_out_count = r_stat_out;
`endif

endmodule
